// File: rtl/and_share_arbiter.sv
// and_share_arbiter: round-robin grant of one registered AND-reduce
// unit among N requesters, with optional locked bursts.
module and_share_arbiter #(
  parameter int N = 3,
  parameter int W = 3,
  parameter int MAX_BURST = 4,
  localparam int IW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   lock,
  input  logic [N*W-1:0] op,
  output logic [N-1:0]   gnt,
  output logic           res_valid,
  output logic [IW-1:0]  res_id,
  output logic           res_and
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam bit CAN_LOCK = (MAX_BURST > 1);

  typedef enum logic {ARB, LOCK} state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] owner;
  logic [CW-1:0] cnt;

  logic [W-1:0]  opv [N];
  logic [IW-1:0] win;
  logic [IW-1:0] idx;
  logic [IW-1:0] nxt;
  logic [CW-1:0] cnt_inc;
  logic          hit;
  logic          win_and;
  int            j;

  for (genvar i = 0; i < N; i++) begin : g_op
    assign opv[i] = op[i*W +: W];
  end

  // Winner search; forced idle while reset is held.
  always_comb begin
    gnt = '0;
    win = '0;
    idx = '0;
    hit = 1'b0;
    j   = 0;
    if (rst_n) begin
      if (state == LOCK) begin
        if (req[owner]) begin
          gnt[owner] = 1'b1;
          win        = owner;
          hit        = 1'b1;
        end
      end else begin
        for (int k = 0; k < N; k++) begin
          j = int'(ptr) + k;
          if (j >= N) j = j - N;
          idx = IW'(j);
          if (!hit && req[idx]) begin
            hit      = 1'b1;
            win      = idx;
            gnt[idx] = 1'b1;
          end
        end
      end
    end
  end

  assign win_and = &opv[win];
  assign nxt     = (win == IW'(N - 1)) ? '0 : win + 1'b1;
  assign cnt_inc = cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ARB;
      ptr       <= '0;
      owner     <= '0;
      cnt       <= '0;
      res_valid <= 1'b0;
      res_id    <= '0;
      res_and   <= 1'b0;
    end else begin
      res_valid <= hit;
      if (hit) begin
        res_id  <= win;
        res_and <= win_and;
      end
      case (state)
        ARB: begin
          if (hit) begin
            ptr <= nxt;
            if (lock[win] && CAN_LOCK) begin
              state <= LOCK;
              owner <= win;
              cnt   <= CW'(1);
            end
          end
        end
        LOCK: begin
          // ptr already points past owner, so it is left alone here
          if (!hit) begin
            state <= ARB;
          end else begin
            cnt <= cnt_inc;
            if (!lock[owner] || cnt_inc == CW'(MAX_BURST))
              state <= ARB;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_and_share_arbiter.sv
// tb_and_share_arbiter: directed and random checks of the shared
// AND-reduce arbiter against a queue-free behavioural model.
module tb_and_share_arbiter;

  localparam int N  = 3;
  localparam int W  = 3;
  localparam int MB = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N-1:0]   lock;
  logic [N*W-1:0] op;
  logic [N-1:0]   gnt;
  logic           res_valid;
  logic [1:0]     res_id;
  logic           res_and;

  int checks   = 0;
  int failures = 0;

  int         m_ptr;
  int         m_owner;
  int         m_cnt;
  int         m_w;
  logic       e_valid;
  int         e_id;
  logic       e_and;
  logic [N-1:0] seen;

  always #5 clk = ~clk;

  and_share_arbiter #(.N(N), .W(W), .MAX_BURST(MB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .lock     (lock),
    .op       (op),
    .gnt      (gnt),
    .res_valid(res_valid),
    .res_id   (res_id),
    .res_and  (res_and)
  );

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] opnd(int i);
    return op[i*W +: W];
  endfunction

  // Who should win this cycle, from the arbitration rules.
  function automatic int winner();
    if (!rst_n) return -1;
    if (m_owner >= 0) return req[m_owner] ? m_owner : -1;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (req[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr   = 0;
    m_owner = -1;
    m_cnt   = 0;
    e_valid = 1'b0;
    e_id    = 0;
    e_and   = 1'b0;
  endtask

  task automatic model_step(int w);
    if (!rst_n) begin
      model_reset();
      return;
    end
    e_valid = (w >= 0);
    if (w < 0) begin
      m_owner = -1;
      return;
    end
    e_id  = w;
    e_and = &opnd(w);
    if (m_owner < 0) begin
      m_ptr = (w + 1) % N;
      if (lock[w] && MB > 1) begin
        m_owner = w;
        m_cnt   = 1;
      end
    end else if (!lock[w]) begin
      m_owner = -1;
    end else begin
      m_cnt++;
      if (m_cnt == MB) m_owner = -1;
    end
  endtask

  task automatic cycle(string tag);
    @(negedge clk);
    m_w  = winner();
    seen = gnt;
    check({tag, ".gnt"}, gnt, (m_w < 0) ? 0 : (1 << m_w));
    @(posedge clk);
    #1;
    model_step(m_w);
    check({tag, ".valid"}, res_valid, e_valid);
    check({tag, ".id"}, res_id, e_id);
    check({tag, ".and"}, res_and, e_and);
  endtask

  task automatic run_expect(string tag, logic [N-1:0] g);
    cycle(tag);
    check({tag, ".seq"}, seen, g);
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '1;
    lock  = '0;
    op    = {3'b111, 3'b011, 3'b111};
    model_reset();
    @(posedge clk);
    #1;

    run_expect("rst0", 3'b000);
    run_expect("rst1", 3'b000);
    check("rst.valid", res_valid, 0);
    check("rst.id", res_id, 0);
    check("rst.and", res_and, 0);

    rst_n = 1'b1;
    run_expect("rr0", 3'b001);
    check("rr0.and", res_and, 1);
    run_expect("rr1", 3'b010);
    check("rr1.and", res_and, 0);
    run_expect("rr2", 3'b100);
    check("rr2.id", res_id, 2);
    run_expect("rr3", 3'b001);

    req = 3'b100;
    repeat (3) begin
      run_expect("single", 3'b100);
      check("single.valid", res_valid, 1);
    end
    req = 3'b111;
    run_expect("wrap", 3'b001);

    rst_n = 1'b0;
    cycle("burst.rst");
    rst_n = 1'b1;
    req   = 3'b011;
    lock  = 3'b001;
    repeat (4) run_expect("burst", 3'b001);
    run_expect("burst.rel", 3'b010);

    rst_n = 1'b0;
    cycle("eu.rst");
    rst_n = 1'b1;
    run_expect("eu0", 3'b001);
    lock = 3'b000;
    run_expect("eu1", 3'b001);
    run_expect("eu2", 3'b010);

    rst_n = 1'b0;
    cycle("od.rst");
    rst_n = 1'b1;
    lock  = 3'b001;
    run_expect("od0", 3'b001);
    req = 3'b010;
    run_expect("od.bubble", 3'b000);
    run_expect("od.next", 3'b010);

    req = 3'b011;
    run_expect("mb0", 3'b001);
    run_expect("mb1", 3'b001);
    rst_n = 1'b0;
    run_expect("mb.rst", 3'b000);
    check("mb.valid", res_valid, 0);
    rst_n = 1'b1;
    lock  = 3'b000;
    run_expect("mb.arb", 3'b001);

    // Random traffic: requests hold until granted, ops stable while pending.
    req = '0;
    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(63) != 0);
      for (int i = 0; i < N; i++) begin
        if (!req[i] && $urandom_range(1) == 1) begin
          req[i] = 1'b1;
          op[i*W +: W] = ($urandom_range(1) == 1) ? '1 : W'($urandom);
        end
      end
      lock = N'($urandom);
      cycle("rnd");
      if (m_w >= 0) begin
        if ($urandom_range(1) == 1) req[m_w] = 1'b0;
        else op[m_w*W +: W] = W'($urandom);
      end
      if (m_owner >= 0 && $urandom_range(7) == 0) req[m_owner] = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/and_share_arbiter.md
# and_share_arbiter

Round-robin arbiter and sequencer that shares one registered AND-reduction unit among N requesters. Each requester presents a W-bit operand with a request. The block grants one requester per cycle, with an optional locked burst. The shared unit reduces the granted operand with AND and registers the result, tagged with the winner's index. The block sits between several producer blocks and the single reduction/register stage used across the lab designs.

## Interface
- N, default 3: number of requesters. Legal range 2..8.
- W, default 3: operand width per requester.
- MAX_BURST, default 4: maximum consecutive beats granted to one locked owner. Legal range ≥1.
- IW: localparam, equal to $clog2(N).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset. Synchronous, active-low: sampled on the rising edge of clk.
- req  input  N  request; bit i belongs to requester i. Held high until granted.
- lock  input  N  bit i high requests that the grant be kept across consecutive beats.
- op  input  N*W  operands; requester i occupies op[i*W +: W].
- gnt  output  N  one-hot grant. Combinational from state and req. All-zero when nothing is granted.
- res_valid  output  1  registered; high for one cycle per accepted beat.
- res_id  output  IW  registered index of the requester whose beat produced the result.
- res_and  output  1  registered AND-reduction of the granted operand.

## Operation
- Handshake rules:
  - A beat is accepted on a rising edge where gnt[i] and req[i] are both high. gnt[i] is never high without req[i].
  - A requester must keep op stable while req is high.
- State registers: state (ARB or LOCK), ptr (IW bits), owner (IW bits), cnt (up to MAX_BURST).
- ARB state:
  - gnt selects the first requester with req high, searching ptr, ptr+1, … wrapping mod N.
  - On acceptance of winner g: ptr <= (g+1) mod N.
  - If lock[g]=1 and MAX_BURST>1: state <= LOCK, owner <= g, cnt <= 1.
  - Otherwise the state stays ARB.
  - With no requests: gnt=0 and ptr is unchanged.
- LOCK state:
  - gnt = one-hot(owner) if req[owner]=1. Other requesters are never granted while in LOCK.
  - req[owner]=0: no grant this cycle (one bubble); state <= ARB.
  - Owner beat accepted with lock[owner]=0: state <= ARB.
  - Owner beat accepted with lock[owner]=1: cnt <= cnt+1. If cnt+1 == MAX_BURST, state <= ARB (forced release).
  - ptr is not modified in LOCK. It already points past the owner, so the owner has lowest priority after release.
- Result stage, on each accepted beat:
  - res_valid <= 1, res_id <= g, res_and <= &op[g].
  - Otherwise res_valid <= 0; res_id and res_and hold their values.
- Reset (rst_n=0 at an edge):
  - state <= ARB, ptr <= 0, owner <= 0, cnt <= 0.
  - res_valid <= 0, res_id <= 0, res_and <= 0.
  - While rst_n is low, gnt is forced to 0 and no beat is accepted. A burst in progress is abandoned.
- Wrap-around: ptr = N-1 and winner N-1 gives ptr <= 0.

## Timing
- Grant is same-cycle combinational: req high in cycle t gives gnt high in cycle t if the requester wins.
- Latency is 1 cycle: a beat accepted at edge t produces res_valid/res_id/res_and valid from edge t until edge t+1.
- Throughput is 1 beat per cycle. The only lost cycle is the bubble when a locked owner drops req.
- After reset deasserts, the first grant is possible in the same cycle rst_n is sampled high.
- No combinational path from op to any output.

## Test plan
- **Reset:** hold rst_n=0 for 2 cycles with req=3'b111. Required: gnt=0, res_valid=0, res_id=0, res_and=0. After release, the first grant is gnt=3'b001.
- **Round-robin, N=3, W=3:** req=3'b111 continuously, lock=0, op0=3'b111, op1=3'b011, op2=3'b111. Required grant sequence 001, 010, 100, 001. Results one cycle later: res_id 0,1,2,0 and res_and 1,0,1,1.
- **Single requester:** only req[2] high for 3 cycles. Required: gnt=3'b100 every cycle, res_valid high on 3 consecutive cycles, ptr wraps to 0.
- **Locked burst with MAX_BURST=4:** req=3'b011, lock[0]=1 throughout. Required: requester 0 granted 4 consecutive beats, then requester 1 granted on the 5th cycle.
- **Early unlock:** requester 0 is locked; lock[0] drops on its 2nd beat. Required: that beat is accepted, and the next cycle grants requester 1.
- **Owner drops req in LOCK, then reset mid-burst:**
  - Owner drops req while locked. Required: one cycle with gnt=0, then ARB grants the next requester.
  - Assert rst_n=0 mid-burst. Required: on the next edge state=ARB and res_valid=0.
